uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding an 8N1 UART transmitter. Bytes are written through a
//   valid/ready handshake. The transmitter drains the FIFO one frame at a
//   time: a start bit, then eight data bits LSB first, then a stop bit. Each
//   bit lasts DIV = CLK_FREQ / BAUD_RATE clock cycles. Frames run back to
//   back with no idle gap while the FIFO still holds bytes.
//
// Parameters
//   CLK_FREQ     clock frequency in Hz
//   BAUD_RATE    serial bit rate in bit/s (CLK_FREQ / BAUD_RATE must be >= 2)
//   FIFO_DEPTH   number of byte entries, a power of two and at least 2
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_ni        synchronous reset, active low
//   wdata_i       byte to transmit
//   wvalid_i      wdata_i is valid
//   wready_o      FIFO can accept a byte (not full)
//   tx_o          registered serial output, idle high
//   busy_o        transmitter is in the middle of a frame
//   fifo_count_o  number of bytes stored
//   fifo_full_o   FIFO holds FIFO_DEPTH bytes
//   fifo_empty_o  FIFO holds no bytes
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    wdata_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          fifo_full_o,
  output logic                          fifo_empty_o
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (DIV > 1) ? $clog2(DIV) : 1;

  // A bit period shorter than two cycles cannot be timed. A FIFO depth
  // that is not a power of two breaks the natural wrap of the pointers.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  bit_timer;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              push;
  logic              pop;
  logic              bit_done;

  assign fifo_full_o  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_o = (count == '0);
  assign wready_o     = !fifo_full_o;
  assign fifo_count_o = count;
  assign busy_o       = (state != IDLE);

  assign push     = wvalid_i && wready_o;
  assign bit_done = (bit_timer == TMR_W'(DIV - 1));

  // The transmitter takes the head byte when it is idle, or as a stop bit
  // ends. The second case lets the next frame start with no idle gap.
  assign pop = !fifo_empty_o &&
               ((state == IDLE) || ((state == STOP) && bit_done));

  // Storage array. It is not reset, because the pointers and the count
  // define which entries are valid. Writes are blocked while reset is
  // held, so wvalid_i is ignored during reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping. A push and a pop on the same edge
  // move both pointers and leave the count unchanged. The pointers are
  // exactly log2(depth) bits wide, so they wrap without extra logic.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer. tx_o is registered here, so each bit appears on the
  // same edge that enters its state. The bit timer restarts from 0 on
  // every bit boundary, so each bit lasts exactly DIV cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      tx_o      <= 1'b1;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            state     <= START;
            tx_o      <= 1'b0;
            bit_timer <= '0;
          end
        end

        START: begin
          if (bit_done) begin
            bit_timer <= '0;
            bit_idx   <= '0;
            tx_o      <= shift_reg[0];
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer + TMR_W'(1);
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_timer <= '0;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            bit_timer <= bit_timer + TMR_W'(1);
          end
        end

        STOP: begin
          if (bit_done) begin
            bit_timer <= '0;
            if (pop) begin
              shift_reg <= mem[rd_ptr];
              tx_o      <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer + TMR_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed, self-checking bench for uart_tx_fifo. The main instance uses
//   DIV = 10 and a 4-entry FIFO. Every accepted byte is pushed to a
//   scoreboard queue. A frame checker pops the expected byte and compares
//   the serial line on every cycle of the frame. A second instance with the
//   default parameters measures the DIV = 217 frame length.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = CLK_FREQ / BAUD_RATE;

  logic       clk;
  logic       rst_n;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;

  logic [7:0] wdata_d;
  logic       wvalid_d;
  logic       wready_d;
  logic       tx_d;
  logic       busy_d;
  logic [4:0] fifo_count_d;
  logic       fifo_full_d;
  logic       fifo_empty_d;

  logic [7:0] sb_q [$];
  int         compared;
  int         mismatched;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wdata_i      (wdata),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_count_o (fifo_count),
    .fifo_full_o  (fifo_full),
    .fifo_empty_o (fifo_empty)
  );

  uart_tx_fifo u_dut_def (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wdata_i      (wdata_d),
    .wvalid_i     (wvalid_d),
    .wready_o     (wready_d),
    .tx_o         (tx_d),
    .busy_o       (busy_d),
    .fifo_count_o (fifo_count_d),
    .fifo_full_o  (fifo_full_d),
    .fifo_empty_o (fifo_empty_d)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report it if it fails
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte at the current falling edge. Check that wready matches
  // the expected acceptance, record the byte if it will be accepted, and
  // then step past the capturing rising edge. wvalid stays asserted.
  task automatic applyStimulus(input logic [7:0] data, input bit accept);
    wvalid = 1'b1;
    wdata  = data;
    checkOutput($sformatf("wready for 0x%02h", data), 32'(wready), 32'(accept));
    if (accept) sb_q.push_back(data);
    @(negedge clk);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " tx"}, 32'(tx), 32'd1);
    checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    checkOutput({tag, " empty"}, 32'(fifo_empty), 32'd1);
  endtask

  // Check one whole frame against the next scoreboard entry. The call
  // starts at cycle first_cycle of the start bit and samples every cycle.
  // It returns on the first cycle after the stop bit. If inject is set, a
  // byte is offered on the last stop cycle, so it is captured on the same
  // edge as the pop for the following frame.
  task automatic checkFrame(input string tag, input int first_cycle,
                            input bit inject, input logic [7:0] inject_data);
    logic [7:0] exp_byte;
    logic [9:0] bits;
    logic       seen_tx;
    logic       seen_busy;
    bit         bad;
    if (sb_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL %s scoreboard: observed empty queue expected a byte", tag);
      exp_byte = 8'h00;
    end else begin
      exp_byte = sb_q.pop_front();
    end
    bits = {1'b1, exp_byte, 1'b0};
    for (int b = 0; b < 10; b++) begin
      bad       = 1'b0;
      seen_tx   = bits[b];
      seen_busy = 1'b1;
      for (int c = (b == 0) ? first_cycle : 0; c < DIV; c++) begin
        if (!bad && (tx !== bits[b] || busy !== 1'b1)) begin
          bad       = 1'b1;
          seen_tx   = tx;
          seen_busy = busy;
        end
        if (inject && b == 9 && c == DIV - 1) begin
          wvalid = 1'b1;
          wdata  = inject_data;
          checkOutput({tag, " inject wready"}, 32'(wready), 32'd1);
          sb_q.push_back(inject_data);
        end
        @(negedge clk);
        if (inject && b == 9 && c == DIV - 1) wvalid = 1'b0;
      end
      checkOutput($sformatf("%s 0x%02h bit%0d {busy,tx}", tag, exp_byte, b),
                  {30'd0, seen_busy, seen_tx}, {30'd0, 1'b1, bits[b]});
    end
  endtask

  initial begin
    logic [7:0] burst [6];
    int         busy_len;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    wvalid     = 1'b0;
    wdata      = 8'h00;
    wvalid_d   = 1'b0;
    wdata_d    = 8'h00;
    burst[0] = 8'h81; burst[1] = 8'h42; burst[2] = 8'h24;
    burst[3] = 8'h18; burst[4] = 8'hF0; burst[5] = 8'h0F;

    // Reset with wvalid held high: the offered byte must be ignored
    @(negedge clk);
    wvalid = 1'b1;
    wdata  = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    checkIdle("reset");
    checkOutput("reset count", 32'(fifo_count), 32'd0);
    checkOutput("reset full", 32'(fifo_full), 32'd0);
    checkOutput("reset wready", 32'(wready), 32'd1);
    wvalid = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    checkOutput("post-reset count", 32'(fifo_count), 32'd0);
    checkOutput("post-reset busy", 32'(busy), 32'd0);

    // Single byte while idle: start bit appears one cycle after acceptance
    applyStimulus(8'hA5, 1'b1);
    wvalid = 1'b0;
    checkOutput("single count after push", 32'(fifo_count), 32'd1);
    checkOutput("single tx before pop", 32'(tx), 32'd1);
    @(negedge clk);
    checkFrame("single", 0, 1'b0, 8'h00);
    checkIdle("single end");

    // Three bytes back to back: contiguous frames with no idle gap
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h55, 1'b1);
    wvalid = 1'b0;
    checkOutput("b2b count", 32'(fifo_count), 32'd2);
    checkFrame("b2b0", 1, 1'b0, 8'h00);
    checkFrame("b2b1", 0, 1'b0, 8'h00);
    checkFrame("b2b2", 0, 1'b0, 8'h00);
    checkIdle("b2b end");

    // wvalid held for six bytes: the FIFO fills and the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      applyStimulus(burst[i], i < 5);
      if (i == 0) begin
        checkOutput("burst count after first", 32'(fifo_count), 32'd1);
        checkOutput("burst tx after first", 32'(tx), 32'd1);
      end else if (i == 1) begin
        checkOutput("burst first popped tx", 32'(tx), 32'd0);
        checkOutput("burst count after pop", 32'(fifo_count), 32'd1);
      end
    end
    wvalid = 1'b0;
    checkOutput("burst full", 32'(fifo_full), 32'd1);
    checkOutput("burst count full", 32'(fifo_count), 32'd4);
    checkOutput("burst wready", 32'(wready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkFrame($sformatf("burst%0d", i), (i == 0) ? 4 : 0, 1'b0, 8'h00);
    end
    checkIdle("burst end");

    // A push on the same edge as the pop at the end of a stop bit
    applyStimulus(8'h3A, 1'b1);
    applyStimulus(8'hC5, 1'b1);
    applyStimulus(8'h69, 1'b1);
    wvalid = 1'b0;
    checkOutput("simul count before", 32'(fifo_count), 32'd2);
    checkFrame("simul0", 1, 1'b1, 8'h96);
    checkOutput("simul count after", 32'(fifo_count), 32'd2);
    checkFrame("simul1", 0, 1'b0, 8'h00);
    checkFrame("simul2", 0, 1'b0, 8'h00);
    checkFrame("simul3", 0, 1'b0, 8'h00);
    checkIdle("simul end");

    // Reset during data bit 3 of 0xC3, with a second byte still queued
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'h11, 1'b1);
    wvalid = 1'b0;
    repeat (45) @(negedge clk);
    checkOutput("abort tx in bit3", 32'(tx), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdle("abort reset");
    checkOutput("abort count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    sb_q.delete();
    repeat (3) @(negedge clk);
    checkIdle("abort released");
    applyStimulus(8'h5C, 1'b1);
    wvalid = 1'b0;
    @(negedge clk);
    checkFrame("after abort", 0, 1'b0, 8'h00);
    checkIdle("after abort end");

    // Default build: DIV = 25_000_000 / 115_200 = 217, frame is 2170 cycles
    wvalid_d = 1'b1;
    wdata_d  = 8'h5A;
    @(negedge clk);
    wvalid_d = 1'b0;
    busy_len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (busy_d) busy_len++;
      else if (busy_len > 0) break;
      @(negedge clk);
    end
    checkOutput("default frame length", 32'(busy_len), 32'd2170);
    checkOutput("default idle {wready,full,empty,count,tx}",
                {23'd0, wready_d, fifo_full_d, fifo_empty_d, fifo_count_d, tx_d},
                {23'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
